// File: rtl/com_pkg.sv
// Shared constants for the comparator-code decoder: code values, relation codes
// and output-stage FSM states.
package com_pkg;

  localparam logic [2:0] COM_GT = 3'b001;
  localparam logic [2:0] COM_LT = 3'b010;
  localparam logic [2:0] COM_EQ = 3'b100;

  typedef enum logic [1:0] {
    REL_EQ  = 2'b00,
    REL_GT  = 2'b01,
    REL_LT  = 2'b10,
    REL_ERR = 2'b11
  } rel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clr beats inc and the
// count sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/com_decoder.sv
// Consumer of the one-hot comparator code: decodes com into max/min/relation
// behind a one-entry registered output stage and keeps saturating tallies.
// Build option: define COM_DECODER_ONEHOT_CHECK_EN for strict one-hot checking
// (illegal codes become ERR); otherwise com is priority-decoded bit0 > bit1 > bit2.
module com_decoder
  import com_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       com,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [1:0]       out_rel,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_err,
  output logic             err_sticky
);

  state_t           state, state_nxt;
  logic             accept;
  rel_t             rel_dec;
  logic [WIDTH-1:0] max_dec, min_dec;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      EMPTY: in_ready = 1'b1;
      FULL:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid && in_ready;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (out_ready && !in_valid) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Relation comes only from com; operand values are never compared.
  always_comb begin
    rel_dec = REL_EQ;
    max_dec = a;
    min_dec = a;
`ifdef COM_DECODER_ONEHOT_CHECK_EN
    case (com)
      COM_GT:  begin rel_dec = REL_GT; max_dec = a; min_dec = b; end
      COM_LT:  begin rel_dec = REL_LT; max_dec = b; min_dec = a; end
      COM_EQ:  begin rel_dec = REL_EQ; max_dec = a; min_dec = a; end
      default: begin rel_dec = REL_ERR; max_dec = '0; min_dec = '0; end
    endcase
`else
    if (com[0]) begin
      rel_dec = REL_GT; max_dec = a; min_dec = b;
    end else if (com[1]) begin
      rel_dec = REL_LT; max_dec = b; min_dec = a;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_max <= '0;
      out_min <= '0;
      out_rel <= REL_EQ;
    end else if (accept) begin
      out_max <= max_dec;
      out_min <= min_dec;
      out_rel <= rel_dec;
    end
  end

  logic inc_err;
`ifdef COM_DECODER_ONEHOT_CHECK_EN
  assign inc_err = accept && (rel_dec == REL_ERR);

  always_ff @(posedge clk) begin
    if (rst || clr)   err_sticky <= 1'b0;
    else if (inc_err) err_sticky <= 1'b1;
  end
`else
  assign inc_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && (rel_dec == REL_GT)), .count(cnt_gt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && (rel_dec == REL_LT)), .count(cnt_lt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && (rel_dec == REL_EQ)), .count(cnt_eq)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc_err), .count(cnt_err)
  );

endmodule

// File: tb/tb_com_decoder.sv
// Randomized self-checking bench for com_decoder: a behavioural model of the
// one-entry output stage and tallies, checked every cycle, plus directed literals.
module tb_com_decoder;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       com = 3'b000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_max, out_min;
  logic [1:0]       out_rel;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] cnt_gt, cnt_lt, cnt_eq, cnt_err;
  logic             err_sticky;

  com_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .com(com), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_rel(out_rel), .clr(clr),
    .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_err(cnt_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one held result plus four tallies.
  bit m_valid = 1'b0;
  int m_max = 0, m_min = 0, m_rel = 0;
  int m_gt = 0, m_lt = 0, m_eq = 0, m_err = 0;
  bit m_sticky = 1'b0;

  function automatic int bump(input int c);
    return (c < MAXC) ? c + 1 : MAXC;
  endfunction

  always @(posedge clk) begin
    bit rdy, acc;
    int rel, mx, mn;
    if (rst) begin
      m_valid = 0; m_max = 0; m_min = 0; m_rel = 0;
      m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0; m_sticky = 0;
    end else begin
      rdy = m_valid ? out_ready : 1'b1;
      acc = in_valid && rdy;
`ifdef COM_DECODER_ONEHOT_CHECK_EN
      if ($countones(com) != 1) begin rel = 3; mx = 0; mn = 0; end
      else if (com == 3'b001)   begin rel = 1; mx = a; mn = b; end
      else if (com == 3'b010)   begin rel = 2; mx = b; mn = a; end
      else                      begin rel = 0; mx = a; mn = a; end
`else
      if (com[0])      begin rel = 1; mx = a; mn = b; end
      else if (com[1]) begin rel = 2; mx = b; mn = a; end
      else             begin rel = 0; mx = a; mn = a; end
`endif
      if (acc) begin
        m_valid = 1; m_max = mx; m_min = mn; m_rel = rel;
        case (rel)
          0: m_eq = bump(m_eq);
          1: m_gt = bump(m_gt);
          2: m_lt = bump(m_lt);
          default: begin m_err = bump(m_err); m_sticky = 1; end
        endcase
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (clr) begin
        m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0; m_sticky = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      check("in_ready", int'(in_ready), rst ? 0 : (m_valid ? int'(out_ready) : 1));
      check("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        check("out_max", int'(out_max), m_max);
        check("out_min", int'(out_min), m_min);
        check("out_rel", int'(out_rel), m_rel);
      end
      check("cnt_gt", int'(cnt_gt), m_gt);
      check("cnt_lt", int'(cnt_lt), m_lt);
      check("cnt_eq", int'(cnt_eq), m_eq);
      check("cnt_err", int'(cnt_err), m_err);
      check("err_sticky", int'(err_sticky), int'(m_sticky));
    end
  end

  task automatic apply(input bit v, input logic [2:0] c, input int aa, input int bb,
                       input bit ordy, input bit cl);
    in_valid  = v;
    com       = c;
    a         = WIDTH'(aa);
    b         = WIDTH'(bb);
    out_ready = ordy;
    clr       = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset then idle
    rst = 1'b1;
    apply(0, 3'b000, 0, 0, 0, 0);
    tick();
    started = 1'b1;
    check("rst_in_ready0", int'(in_ready), 0);
    tick();
    check("rst_in_ready1", int'(in_ready), 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_cnt_sum", int'(cnt_gt) + int'(cnt_lt) + int'(cnt_eq) + int'(cnt_err), 0);

    // 2. single GT, then stall with a competing request presented
    apply(1, 3'b001, 20, 7, 0, 0);
    tick();
    check("gt_valid", int'(out_valid), 1);
    check("gt_max", int'(out_max), 20);
    check("gt_min", int'(out_min), 7);
    check("gt_rel", int'(out_rel), 1);
    check("gt_cnt", int'(cnt_gt), 1);
    apply(1, 3'b100, 3, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_max", int'(out_max), 20);
      check("stall_ready", int'(in_ready), 0);
      check("stall_valid", int'(out_valid), 1);
    end
    apply(0, 3'b000, 0, 0, 1, 0);
    tick();
    check("drain_valid", int'(out_valid), 0);

    // 3. back-to-back stream
    apply(1, 3'b010, 3, 9, 1, 0);
    tick();
    check("lt_max", int'(out_max), 9);
    check("lt_min", int'(out_min), 3);
    check("lt_rel", int'(out_rel), 2);
    apply(1, 3'b100, 12, 12, 1, 0);
    tick();
    check("eq_max", int'(out_max), 12);
    check("eq_min", int'(out_min), 12);
    check("eq_rel", int'(out_rel), 0);
    apply(1, 3'b001, 31, 0, 1, 0);
    tick();
    check("gt2_max", int'(out_max), 31);
    check("gt2_min", int'(out_min), 0);
    check("gt2_rel", int'(out_rel), 1);
    apply(0, 3'b000, 0, 0, 1, 0);
    tick();
    check("b2b_cnt_lt", int'(cnt_lt), 1);
    check("b2b_cnt_eq", int'(cnt_eq), 1);
    check("b2b_cnt_gt", int'(cnt_gt), 2);

    // 4. illegal code
    apply(1, 3'b011, 5, 9, 1, 0);
    tick();
`ifdef COM_DECODER_ONEHOT_CHECK_EN
    check("ill_rel", int'(out_rel), 3);
    check("ill_max", int'(out_max), 0);
    check("ill_min", int'(out_min), 0);
    check("ill_cnt_err", int'(cnt_err), 1);
    check("ill_sticky", int'(err_sticky), 1);
`else
    check("ill_rel", int'(out_rel), 1);
    check("ill_max", int'(out_max), 5);
    check("ill_min", int'(out_min), 9);
    check("ill_cnt_err", int'(cnt_err), 0);
    check("ill_sticky", int'(err_sticky), 0);
`endif
    apply(0, 3'b000, 0, 0, 1, 0);
    tick();

    // 5. saturation, then clr coinciding with an accept
    apply(1, 3'b100, 7, 7, 1, 0);
    for (int i = 0; i < 300; i++) tick();
    check("sat_cnt_eq", int'(cnt_eq), 255);
    apply(1, 3'b100, 17, 17, 1, 1);
    tick();
    check("clr_cnt_eq", int'(cnt_eq), 0);
    check("clr_cnt_gt", int'(cnt_gt), 0);
    check("clr_valid", int'(out_valid), 1);
    check("clr_max", int'(out_max), 17);
    apply(0, 3'b000, 0, 0, 1, 0);
    tick();

    // 6. reset mid-operation
    apply(1, 3'b001, 4, 2, 0, 0);
    tick();
    apply(0, 3'b000, 0, 0, 0, 0);
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_max", int'(out_max), 0);
    check("mid_rst_cnt_gt", int'(cnt_gt), 0);
    rst = 1'b0;
    tick();

    // Randomized traffic with occasional clr and reset
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] c;
      if ($urandom_range(3) != 0) begin
        case ($urandom_range(2))
          0: c = 3'b001;
          1: c = 3'b010;
          default: c = 3'b100;
        endcase
      end else begin
        c = 3'($urandom_range(7));
      end
      apply(bit'($urandom_range(1)), c, int'($urandom_range(31)), int'($urandom_range(31)),
            bit'($urandom_range(3) != 0), bit'($urandom_range(49) == 0));
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 1'b0;
    apply(0, 3'b000, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
